// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment score display: digit scanner, double-dabble BCD
// converter with saturation, and start/play/game-over rendering with blink.
module seg7_scan_display #(
  parameter int unsigned DIGITS    = 8,
  parameter int unsigned SCORE_W   = 12,
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 25
) (
  input  logic               vga_clk,
  input  logic               rst,
  input  logic               waiting,
  input  logic               over,
  input  logic [SCORE_W-1:0] score,
  output logic [6:0]         HEX,
  output logic [DIGITS-1:0]  sec,
  output logic               bcd_valid
);

  localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W  = $clog2(DIGITS);
  localparam int unsigned BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(SCORE_W);
  localparam int unsigned DISP_W = 4 * DIGITS;
  localparam int unsigned ACC_W  = 4 * DIGITS + 4;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} state_t;

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  sec_q, sec_d;
  logic [6:0]         hex_q, hex_d;
  logic [BLK_W-1:0]   blink_q, blink_d;
  logic               phase_q, phase_d;
  logic               over_q, over_d;
  logic               frame_end;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] cap_q, cap_d;
  logic [SCORE_W-1:0] sh_q, sh_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic [DISP_W-1:0]  disp_q, disp_d;
  logic               valid_q, valid_d;
  logic               conv_start;
  logic [ACC_W-1:0]   dab;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [ACC_W-1:0] dabble(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i <= int'(DIGITS); i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Scan prescaler, digit index and blink timer
  always_comb begin
    presc_d   = presc_q + PRE_W'(1);
    idx_d     = idx_q;
    frame_end = 1'b0;
    if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
      presc_d   = '0;
      frame_end = (idx_q == IDX_W'(DIGITS - 1));
      idx_d     = frame_end ? '0 : idx_q + IDX_W'(1);
    end

    over_d  = over;
    blink_d = blink_q;
    phase_d = phase_q;
    if (!over || !over_q) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (frame_end) begin
      if (blink_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BLK_W'(1);
      end
    end
  end

  // Render the digit that becomes selected this cycle so sec and HEX stay paired
  always_comb begin
    logic             any_nz;
    logic [DIGITS-1:0] lead_zero;
    logic [3:0]       nib;
    logic             lz;
    any_nz    = 1'b0;
    lead_zero = '0;
    nib       = 4'd0;
    lz        = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      any_nz       = any_nz | (|disp_q[4*i +: 4]);
      lead_zero[i] = !any_nz && (i != 0);
    end
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib = disp_q[4*i +: 4];
        lz  = lead_zero[i];
      end
    end
    sec_d = ~(DIGITS'(1) << idx_d);
    if (waiting || !valid_q)  hex_d = SEG_DASH;
    else if (over && phase_d) hex_d = SEG_BLANK;
    else if (lz)              hex_d = SEG_BLANK;
    else                      hex_d = seg_decode(nib);
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      sec_q   <= ~DIGITS'(1);
      hex_q   <= SEG_BLANK;
      blink_q <= '0;
      phase_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sec_q   <= sec_d;
      hex_q   <= hex_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      over_q  <= over_d;
    end
  end

  // Converter FSM state register
  always_ff @(posedge vga_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign conv_start = pending_q || (score != cap_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (conv_start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Converter datapath; ovf catches digits shifted out past the accumulator top
  always_comb begin
    cap_d     = cap_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    disp_d    = disp_q;
    valid_d   = valid_q;
    dab       = dabble(acc_q);
    case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          cap_d     = score;
          sh_d      = score;
          acc_d     = '0;
          ovf_d     = 1'b0;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        acc_d = {dab[ACC_W-2:0], sh_q[SCORE_W-1]};
        ovf_d = ovf_q | dab[ACC_W-1];
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_LOAD: begin
        valid_d = 1'b1;
        if (ovf_q || (|acc_q[ACC_W-1:DISP_W])) disp_d = {DIGITS{4'h9}};
        else                                   disp_d = acc_q[DISP_W-1:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      cap_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      pending_q <= 1'b1;
      disp_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      valid_q   <= valid_d;
    end
  end

  assign HEX       = hex_q;
  assign sec       = sec_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: three instances (8, 3 and 4 digits)
// share stimulus; expected per-digit codes come from an integer decimal model.
module tb_seg7_scan_display;

  localparam int unsigned SW = 12;
  localparam int unsigned SD = 4;
  localparam int unsigned BD = 2;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, waiting, over;
  logic [SW-1:0] score;
  logic [6:0]    hex0, hex1, hex2;
  logic [7:0]    sec0;
  logic [2:0]    sec1;
  logic [3:0]    sec2;
  logic          v0, v1, v2;

  seg7_scan_display #(.DIGITS(8), .SCORE_W(SW), .SCAN_DIV(SD), .BLINK_DIV(BD)) u0 (
    .vga_clk(clk), .rst(rst), .waiting(waiting), .over(over), .score(score),
    .HEX(hex0), .sec(sec0), .bcd_valid(v0));
  seg7_scan_display #(.DIGITS(3), .SCORE_W(SW), .SCAN_DIV(SD), .BLINK_DIV(BD)) u1 (
    .vga_clk(clk), .rst(rst), .waiting(waiting), .over(over), .score(score),
    .HEX(hex1), .sec(sec1), .bcd_valid(v1));
  seg7_scan_display #(.DIGITS(4), .SCORE_W(SW), .SCAN_DIV(SD), .BLINK_DIV(BD)) u2 (
    .vga_clk(clk), .rst(rst), .waiting(waiting), .over(over), .score(score),
    .HEX(hex2), .sec(sec2), .bcd_valid(v2));

  typedef struct {
    logic [7:0] sec;
    logic [6:0] hex;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ndig(input int k);
    case (k)
      0:       return 8;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] get_sec(input int k);
    case (k)
      0:       return sec0;
      1:       return {5'h1F, sec1};
      default: return {4'hF, sec2};
    endcase
  endfunction

  function automatic logic [6:0] get_hex(input int k);
    case (k)
      0:       return hex0;
      1:       return hex1;
      default: return hex2;
    endcase
  endfunction

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic int pw10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // mode: 0 = number, 1 = dashes, 2 = blank
  function automatic logic [6:0] model_hex(input int nd, input int value, input int mode, input int d);
    int v;
    if (mode == 1) return DASH;
    if (mode == 2) return BLANK;
    v = (value >= pw10(nd)) ? pw10(nd) - 1 : value;
    if (d > 0 && v < pw10(d)) return BLANK;
    return seg((v / pw10(d)) % 10);
  endfunction

  task automatic push_frame(input int k, input int value, input int mode);
    exp_t e;
    for (int d = 0; d < ndig(k); d++) begin
      e.sec = ~(8'(1) << d);
      e.hex = model_hex(ndig(k), value, mode, d);
      sb.push_back(e);
    end
  endtask

  task automatic push_all(input int value, input int mode);
    for (int k = 0; k < 3; k++) push_frame(k, value, mode);
  endtask

  // Sync to the next fresh digit-0 slot, then pop and compare one frame
  task automatic check_frame(input int k, input string tag);
    logic [7:0] prev;
    bit         found;
    exp_t       e;
    prev  = get_sec(k);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (get_sec(k) == 8'hFE && prev != 8'hFE) found = 1'b1;
      else prev = get_sec(k);
    end
    check_eq({tag, "_sync"}, 32'(found), 32'd1);
    if (!found) begin
      for (int d = 0; d < ndig(k); d++) if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    for (int d = 0; d < ndig(k); d++) begin
      if (d > 0) @(negedge clk);
      e = sb.pop_front();
      check_eq({tag, "_sec"}, 32'(get_sec(k)), 32'(e.sec));
      check_eq({tag, "_hex"}, 32'(get_hex(k)), 32'(e.hex));
      repeat (SD - 1) @(negedge clk);
      check_eq({tag, "_dwell"}, {17'd0, get_sec(k), get_hex(k)}, {17'd0, e.sec, e.hex});
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) check_frame(k, tag);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_sec0"}, 32'(get_sec(0)), 32'h0FE);
    check_eq({tag, "_sec1"}, 32'(get_sec(1)), 32'h0FE);
    check_eq({tag, "_sec2"}, 32'(get_sec(2)), 32'h0FE);
    check_eq({tag, "_hex"}, {11'd0, hex0, hex1, hex2}, {11'd0, BLANK, BLANK, BLANK});
    check_eq({tag, "_valid"}, {29'd0, v0, v1, v2}, 32'd0);
  endtask

  // Release reset and count cycles until bcd_valid rises
  task automatic release_and_time(input string tag);
    int n;
    rst = 1'b0;
    n = 0;
    while (n < 100 && !v0) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 32'(n), 32'(SW + 2));
    check_eq({tag, "_all"}, {30'd0, v1, v2}, 32'd3);
  endtask

  initial begin
    exp_t       e;
    logic [6:0] last;
    rst = 1'b1; waiting = 1'b0; over = 1'b0; score = '0;
    @(negedge clk); @(negedge clk);
    check_reset("reset");

    release_and_time("lat_zero");
    push_all(0, 0);
    check_all("score0");

    score = SW'(123); push_all(123, 0);
    repeat (40) @(negedge clk);
    check_all("score123");

    score = SW'(1234); push_all(1234, 0);
    repeat (40) @(negedge clk);
    check_all("score1234");

    score = SW'(4095); push_all(4095, 0);
    repeat (40) @(negedge clk);
    check_all("score4095");

    // 3-digit instance: 7 -> 8 -> 9 (9 arrives while 8 converts)
    last = seg(9);
    fork
      begin
        score = SW'(7);
        e.sec = 8'hFE; e.hex = seg(7); sb.push_back(e);
        repeat (40) @(negedge clk);
        score = SW'(8);
        e.hex = seg(8); sb.push_back(e);
        @(negedge clk);
        score = SW'(9);
        e.hex = seg(9); sb.push_back(e);
      end
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clk);
          if (get_sec(1) == 8'hFE && get_hex(1) != last) begin
            last = get_hex(1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check_eq("seq", 32'(last), 32'(e.hex));
            end else begin
              check_eq("seq_extra", 32'(sb.size()), 32'd1);
            end
          end
        end
      end
    join
    check_eq("seq_drain", 32'(sb.size()), 32'd0);

    waiting = 1'b1; push_all(0, 1);
    repeat (2) @(negedge clk);
    check_all("waiting");
    over = 1'b1; push_all(0, 1);
    check_all("wait_over");
    waiting = 1'b0; over = 1'b0;

    // Reset pulse mid-conversion
    score = SW'(999);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("abort");
    release_and_time("lat_abort");
    push_all(999, 0);
    repeat (4) @(negedge clk);
    check_all("score999");

    // Game-over blink: frames 2,3 dark, 4,5 visible
    for (int k = 0; k < 3; k++) begin
      over = 1'b1; waiting = 1'b0; score = SW'(45);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      push_frame(k, 45, 2); push_frame(k, 45, 2);
      push_frame(k, 45, 0); push_frame(k, 45, 0);
      repeat (2 * ndig(k) * SD - 1) @(negedge clk);
      for (int f = 0; f < 4; f++) check_frame(k, "blink");
    end
    waiting = 1'b1; push_all(45, 1);
    repeat (2) @(negedge clk);
    check_all("over_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter DIGITS, default 8, number of multiplexed digits (legal 3..8).
REQ-002 Parameter SCORE_W, default 12, score width in bits (legal 4..20).
REQ-003 Parameter SCAN_DIV, default 1000, vga_clk cycles each digit stays selected (legal >= 2).
REQ-004 Parameter BLINK_DIV, default 25, scan frames per blink half-period in over mode (legal >= 1).
REQ-005 vga_clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  one clock; reset is synchronous and active-high.
REQ-007 waiting  input  1  start-screen mode request.
REQ-008 over  input  1  game-over mode request.
REQ-009 score  input  SCORE_W  unsigned binary score.
REQ-010 HEX  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}, registered.
REQ-011 sec  output  DIGITS  digit select, active-low one-cold, registered.
REQ-012 bcd_valid  output  1  high once the display register holds a completed conversion.

Function
REQ-013 Prescaler SHALL count 0..SCAN_DIV-1; on the terminal count it wraps to 0 and the digit index advances by 1, wrapping DIGITS-1 -> 0.
REQ-014 sec SHALL be low only at bit = digit index; HEX SHALL be registered in the same cycle as sec so both refer to the same digit.
REQ-015 A frame SHALL be one complete index sweep; frame count feeds the blink timer.
REQ-016 Converter FSM states SHALL be IDLE, SHIFT, LOAD.
REQ-017 IDLE: if pending flag set or score != last captured score, capture score, clear BCD accumulator (4*DIGITS+4 bits), clear pending, go SHIFT.
REQ-018 SHIFT: exactly SCORE_W cycles of double-dabble (each nibble >= 5 gets +3, then shift left one bit inserting the next score MSB), then LOAD.
REQ-019 LOAD: if any accumulator bit above 4*DIGITS-1 is set, display register SHALL be all nibbles 9 (saturation); else low 4*DIGITS bits copied; bcd_valid set to 1; go IDLE.
REQ-020 Score changes during SHIFT SHALL be ignored until return to IDLE; worst-case update latency is 2*(SCORE_W+2) cycles; display register SHALL never show a partial conversion.
REQ-021 Mode priority: waiting > over > play.
REQ-022 Waiting: every digit SHALL show dash 7'b0111111.
REQ-023 Play: digit value decoded 0-9 (0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000); leading zeros above the most significant nonzero digit blank (7'b1111111); digit 0 always shown.
REQ-024 Over: play rendering during visible phase, all blank during dark phase; phase toggles every BLINK_DIV frames.
REQ-025 Blink counter and phase SHALL clear to visible phase on the cycle over rises (0->1) and while over is low.
REQ-026 bcd_valid low: play and over modes SHALL show dash on all digits.

Reset
REQ-027 While rst high: prescaler 0, index 0, sec = all ones except bit 0 low, HEX = 7'b1111111, display register 0, bcd_valid 0, FSM IDLE, pending flag 1, blink counter 0, visible phase.
REQ-028 rst asserted mid-SHIFT SHALL abort conversion; first cycle after release begins a fresh conversion of current score.

Verification
REQ-029 DIGITS=8, SCAN_DIV=4, score=123, play -> after conversion, sec cycles FE,FD,FB,...,7F each 4 cycles; HEX = 3,2,1 codes then 7'b1111111 on digits 3-7.
REQ-030 score=0, play -> digit 0 shows 7'b1000000, digits 1-7 blank; bcd_valid rises SCORE_W+2 cycles after reset release.
REQ-031 DIGITS=3, SCORE_W=12, score=1234 -> all three digits show 9 (7'b0010000).
REQ-032 over=1, score=45, BLINK_DIV=2, DIGITS=4, SCAN_DIV=4 -> 45 visible 32 cycles, blank 32 cycles, repeating; waiting=1 simultaneously -> all dashes.
REQ-033 score 7->8 then ->9 one cycle later during SHIFT -> display goes 7, 8, 9 in order, never an intermediate value.
REQ-034 rst pulsed for one cycle mid-SHIFT with score=999 -> outputs return to reset values, bcd_valid 0, then 999 displayed within SCORE_W+2 cycles.
